// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing, cm conversion and
// a confirm-count hysteresis that drives the obstacle-present stop flag.
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES    = 1000,
    parameter int PERIOD_CYCLES  = 6000000,
    parameter int TIMEOUT_CYCLES = 3000000,
    parameter int CM_DIV         = 5800,
    parameter int STOP_CM        = 10,
    parameter int CLEAR_CM       = 15,
    parameter int CONFIRM        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] distance_cm,
    output logic       dist_valid,
    output logic       timeout,
    output logic       stop
);

    localparam int PER_W = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
    localparam int TRG_W = (TRIG_CYCLES    > 1) ? $clog2(TRIG_CYCLES)    : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SUB_W = (CM_DIV         > 1) ? $clog2(CM_DIV)         : 1;
    localparam int CNF_W = $clog2(CONFIRM + 1);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIG_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CM_DIV - 1);
    localparam logic [CNF_W-1:0] CNF_MAX  = CNF_W'(CONFIRM);
    localparam logic [8:0]       CM_MAX   = 9'd511;
    localparam logic [8:0]       STOP_T   = 9'(STOP_CM);
    localparam logic [8:0]       CLEAR_T  = 9'(CLEAR_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE
    } state_t;

    function automatic logic [8:0] cm_sat_inc(input logic [8:0] v);
        return (v == CM_MAX) ? v : v + 9'd1;
    endfunction

    function automatic logic [CNF_W-1:0] cnf_sat_inc(input logic [CNF_W-1:0] v);
        return (v >= CNF_MAX) ? CNF_MAX : v + CNF_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic             echo_meta_q, echo_meta_d;
    logic             echo_sync_q, echo_sync_d;
    logic             echo_prev_q, echo_prev_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [TRG_W-1:0] trg_cnt_q, trg_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [8:0]       cm_cnt_q, cm_cnt_d;
    logic [8:0]       res_cm_q, res_cm_d;
    logic             res_tmo_q, res_tmo_d;
    logic [CNF_W-1:0] near_cnt_q, near_cnt_d;
    logic [CNF_W-1:0] far_cnt_q, far_cnt_d;
    logic             trig_q, trig_d;
    logic [8:0]       distance_q, distance_d;
    logic             dist_valid_q, dist_valid_d;
    logic             timeout_q, timeout_d;
    logic             stop_q, stop_d;

    logic             echo_rise, echo_fall;
    logic [SUB_W-1:0] sub_nxt;
    logic [8:0]       cm_nxt;
    logic [CNF_W-1:0] near_nxt, far_nxt;
    logic             is_near, is_far;

    assign echo_rise = echo_sync_q & ~echo_prev_q;
    assign echo_fall = ~echo_sync_q & echo_prev_q;

    always_comb begin
        state_d      = state_q;
        echo_meta_d  = echo;
        echo_sync_d  = echo_meta_q;
        echo_prev_d  = echo_sync_q;
        per_cnt_d    = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + PER_W'(1);
        trg_cnt_d    = trg_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        sub_cnt_d    = sub_cnt_q;
        cm_cnt_d     = cm_cnt_q;
        res_cm_d     = res_cm_q;
        res_tmo_d    = res_tmo_q;
        near_cnt_d   = near_cnt_q;
        far_cnt_d    = far_cnt_q;
        trig_d       = trig_q;
        distance_d   = distance_q;
        dist_valid_d = 1'b0;
        timeout_d    = timeout_q;
        stop_d       = stop_q;

        // Tick of the echo-high timer, including the current MEASURE cycle
        if (sub_cnt_q == SUB_LAST) begin
            sub_nxt = '0;
            cm_nxt  = cm_sat_inc(cm_cnt_q);
        end else begin
            sub_nxt = sub_cnt_q + SUB_W'(1);
            cm_nxt  = cm_cnt_q;
        end

        is_near  = !res_tmo_q && (res_cm_q <= STOP_T);
        is_far   = res_tmo_q || (res_cm_q >= CLEAR_T);
        near_nxt = cnf_sat_inc(near_cnt_q);
        far_nxt  = cnf_sat_inc(far_cnt_q);

        case (state_q)
            IDLE: begin
                trig_d = 1'b0;
                if (per_cnt_q == PER_LAST) begin
                    state_d   = TRIG;
                    trig_d    = 1'b1;
                    trg_cnt_d = '0;
                    per_cnt_d = '0;
                end
            end
            TRIG: begin
                if (trg_cnt_q == TRG_LAST) begin
                    state_d   = WAIT_RISE;
                    trig_d    = 1'b0;
                    tmo_cnt_d = '0;
                end else begin
                    trg_cnt_d = trg_cnt_q + TRG_W'(1);
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d   = MEASURE;
                    sub_cnt_d = '0;
                    cm_cnt_d  = '0;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = DONE;
                    res_cm_d  = CM_MAX;
                    res_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            MEASURE: begin
                sub_cnt_d = sub_nxt;
                cm_cnt_d  = cm_nxt;
                if (echo_fall) begin
                    state_d   = DONE;
                    res_cm_d  = cm_nxt;
                    res_tmo_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = DONE;
                    res_cm_d  = CM_MAX;
                    res_tmo_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            DONE: begin
                state_d      = IDLE;
                distance_d   = res_cm_q;
                timeout_d    = res_tmo_q;
                dist_valid_d = 1'b1;
                // In-band readings clear both counts so confirmation must be consecutive
                if (is_near) begin
                    near_cnt_d = near_nxt;
                    far_cnt_d  = '0;
                    if (near_nxt == CNF_MAX) stop_d = 1'b1;
                end else if (is_far) begin
                    far_cnt_d  = far_nxt;
                    near_cnt_d = '0;
                    if (far_nxt == CNF_MAX) stop_d = 1'b0;
                end else begin
                    near_cnt_d = '0;
                    far_cnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                trig_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            echo_meta_q  <= 1'b0;
            echo_sync_q  <= 1'b0;
            echo_prev_q  <= 1'b0;
            per_cnt_q    <= '0;
            trg_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            sub_cnt_q    <= '0;
            cm_cnt_q     <= '0;
            res_cm_q     <= CM_MAX;
            res_tmo_q    <= 1'b0;
            near_cnt_q   <= '0;
            far_cnt_q    <= '0;
            trig_q       <= 1'b0;
            distance_q   <= CM_MAX;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            echo_meta_q  <= echo_meta_d;
            echo_sync_q  <= echo_sync_d;
            echo_prev_q  <= echo_prev_d;
            per_cnt_q    <= per_cnt_d;
            trg_cnt_q    <= trg_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            cm_cnt_q     <= cm_cnt_d;
            res_cm_q     <= res_cm_d;
            res_tmo_q    <= res_tmo_d;
            near_cnt_q   <= near_cnt_d;
            far_cnt_q    <= far_cnt_d;
            trig_q       <= trig_d;
            distance_q   <= distance_d;
            dist_valid_q <= dist_valid_d;
            timeout_q    <= timeout_d;
            stop_q       <= stop_d;
        end
    end

    assign trig        = trig_q;
    assign distance_cm = distance_q;
    assign dist_valid  = dist_valid_q;
    assign timeout     = timeout_q;
    assign stop        = stop_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scoreboard bench for ultrasonic_ranger: directed echo widths with
// hand-computed distance/timeout/stop results checked on each dist_valid.
module tb_ultrasonic_ranger;

    logic       clk = 1'b0;
    logic       rst;
    logic       echo;
    logic       trig;
    logic [8:0] distance_cm;
    logic       dist_valid;
    logic       timeout;
    logic       stop;

    always #5 clk = ~clk;

    ultrasonic_ranger #(
        .TRIG_CYCLES   (10),
        .PERIOD_CYCLES (2000),
        .TIMEOUT_CYCLES(1000),
        .CM_DIV        (20),
        .STOP_CM       (10),
        .CLEAR_CM      (15),
        .CONFIRM       (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .echo       (echo),
        .trig       (trig),
        .distance_cm(distance_cm),
        .dist_valid (dist_valid),
        .timeout    (timeout),
        .stop       (stop)
    );

    typedef struct {
        int cm;
        int tmo;
        int stp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_valid = 1'b0;

    // echo length in cycles (0 = no echo), expected cm, timeout, stop
    localparam int NV = 25;
    int v_len[NV] = '{0,
                      240, 219, 220,
                      170, 170, 170, 410, 410, 250, 410, 410, 410,
                      170, 170, 250, 170,
                      170, 170, 1500, 1500, 1500,
                      170, 170, 170};
    int v_cm[NV]  = '{511,
                      12, 10, 11,
                      8, 8, 8, 20, 20, 12, 20, 20, 20,
                      8, 8, 12, 8,
                      8, 8, 511, 511, 511,
                      8, 8, 8};
    int v_tmo[NV] = '{1,
                      0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 0,
                      0, 0, 0, 0,
                      0, 0, 1, 1, 1,
                      0, 0, 0};
    int v_stp[NV] = '{0,
                      0, 0, 0,
                      0, 0, 1, 1, 1, 1, 1, 1, 0,
                      0, 0, 0, 0,
                      0, 1, 1, 1, 0,
                      0, 0, 1};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (dist_valid) begin
                if (prev_valid) chk("dist_valid_width", 2, 1);
                if (sb.size() == 0) begin
                    chk("unexpected_dist_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("distance_cm", int'(distance_cm), e.cm);
                    chk("timeout", int'(timeout), e.tmo);
                    chk("stop", int'(stop), e.stp);
                end
            end
            prev_valid <= dist_valid;
        end
    end

    task automatic wait_trig(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 2500 && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (trig) ok = 1'b1;
        end
        if (!ok) chk("trig_rise_seen", 0, 1);
    endtask

    task automatic wait_trig_fall();
        int w;
        w = 0;
        while (trig && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("trig_width", w, 10);
    endtask

    task automatic run_meas(input int len, input int cm, input int tmo, input int stp,
                            input bit first);
        int   n;
        bit   ok;
        exp_t e;
        wait_trig(n, ok);
        if (ok) begin
            if (first) chk("trig_after_reset", n, 2000);
            wait_trig_fall();
            e.cm  = cm;
            e.tmo = tmo;
            e.stp = stp;
            sb.push_back(e);
            if (len > 0) begin
                echo = 1'b1;
                repeat (len) @(posedge clk);
                #1;
                echo = 1'b0;
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  ok;
        rst  = 1'b1;
        echo = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_trig", int'(trig), 0);
        chk("rst_distance", int'(distance_cm), 511);
        chk("rst_dist_valid", int'(dist_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_stop", int'(stop), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_meas(v_len[i], v_cm[i], v_tmo[i], v_stp[i], i == 0);

        // Reset in the middle of a measurement with stop set
        wait_trig(n, ok);
        if (ok) begin
            wait_trig_fall();
            echo = 1'b1;
            repeat (100) @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk("midrst_trig", int'(trig), 0);
            chk("midrst_stop", int'(stop), 0);
            chk("midrst_distance", int'(distance_cm), 511);
            chk("midrst_dist_valid", int'(dist_valid), 0);
            chk("midrst_timeout", int'(timeout), 0);
            echo = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            run_meas(240, 12, 0, 0, 1'b1);
        end

        n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) chk("pending_results", sb.size(), 0);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Drives an HC-SR04-style ultrasonic sensor: fires trigger pulses periodically, times the echo, and converts the time to centimetres.
- Applies a debounced stop/clear hysteresis to the result.
- Sits directly upstream of the mission state machine and the arm servo controller, which consume `stop`.
- Also exports the distance for display and debug.

Parameters:
- TRIG_CYCLES, 1000: trig high time in clk cycles (10 us at 100 MHz).
- PERIOD_CYCLES, 6000000: trigger-to-trigger interval (60 ms).
- TIMEOUT_CYCLES, 3000000: max wait for echo rise, and max echo high time (30 ms).
- CM_DIV, 5800: clk cycles of echo-high per centimetre (58 us/cm).
- STOP_CM, 10: reading <= STOP_CM counts as "near".
- CLEAR_CM, 15: reading >= CLEAR_CM counts as "far". Must be > STOP_CM.
- CONFIRM, 3: consecutive qualifying readings needed to change `stop`.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: asynchronous, active-high reset.
- echo, input, 1: raw sensor echo, asynchronous to clk.
- trig, output, 1: sensor trigger pulse.
- distance_cm, output, 9: last completed reading; saturates at 511.
- dist_valid, output, 1: one-cycle pulse when distance_cm updates.
- timeout, output, 1: level; 1 if the last reading timed out.
- stop, output, 1: obstacle-present flag with hysteresis.

Behaviour:
- Reset values: trig=0, distance_cm=511, dist_valid=0, timeout=0, stop=0. FSM in IDLE; all counters 0; near/far counters 0.
- echo passes through a 2-flop synchroniser. Edge detection uses the synchronised signal and its one-cycle delayed copy. Synchroniser latency (2 cycles) is accepted and is not compensated.
- Period counter: 0..PERIOD_CYCLES-1, restarts at 0 on entry to TRIG. A new measurement begins only when IDLE sees the period counter at PERIOD_CYCLES-1. The first trigger after reset occurs PERIOD_CYCLES cycles after reset release.
- FSM states:
  - IDLE: trig=0. Leave to TRIG on period expiry.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE.
  - WAIT_RISE: wait for synchronised echo rising edge, then MEASURE with the cm and sub counters cleared. If TIMEOUT_CYCLES elapse first, go to DONE with a timeout result.
  - MEASURE: sub counter increments each cycle. When it reaches CM_DIV-1 it wraps to 0 and the cm counter increments, saturating at 511.
    - Falling edge: go to DONE with result = cm counter (floor of cycles/CM_DIV).
    - Echo high for TIMEOUT_CYCLES: go to DONE with a timeout result.
  - DONE: single cycle. Load distance_cm, pulse dist_valid, update timeout and the hysteresis counters, then go to IDLE.
- Timeout result: distance_cm=511, timeout=1. A normal result sets timeout=0.
- An echo already high on entry to WAIT_RISE is not a rising edge; a real rise must occur.
- An echo edge arriving in IDLE or TRIG is ignored.
- Hysteresis, evaluated in DONE:
  - reading <= STOP_CM: near_cnt increments (saturating at CONFIRM), far_cnt clears.
  - reading >= CLEAR_CM, or timeout: far_cnt increments (saturating), near_cnt clears.
  - reading strictly between the thresholds: both counters clear; stop holds.
  - stop sets in the same cycle that near_cnt reaches CONFIRM. It clears in the same cycle that far_cnt reaches CONFIRM.
  - stop is registered and changes only in the DONE cycle.
- Reset mid-operation (any state) forces the reset values immediately. trig drops asynchronously.
- Widths: sub counter ceil(log2(CM_DIV)) bits. Period and timeout counters are sized from their parameters. No arithmetic overflow is permitted.

Test Plan (bench overrides TRIG_CYCLES=10, PERIOD_CYCLES=2000, TIMEOUT_CYCLES=1000, CM_DIV=20, CONFIRM=3):
1. Release reset with echo=0 -> trig rises at cycle 2000 and is high for exactly 10 cycles. After 1000 more cycles, dist_valid pulses with distance_cm=511 and timeout=1. stop stays 0.
2. Echo high for 240 cycles after trig falls -> distance_cm=12, timeout=0, single dist_valid pulse. Echo of 219 cycles -> 10. Echo of 220 cycles -> 11.
3. Three consecutive 8 cm readings -> stop=1 exactly at the third dist_valid. Then two 20 cm readings, one 12 cm reading, and three 20 cm readings -> stop stays 1 until the final third 20 cm reading, then clears.
4. Near, near, 12 cm, near -> stop remains 0 because the in-band reading reset the count.
5. Echo stuck high -> MEASURE ends after 1000 cycles with distance_cm=511 and timeout=1. Three such timeouts while stop=1 -> stop clears.
6. Assert rst during MEASURE -> trig=0, stop=0, distance_cm=511 immediately. The next trigger comes 2000 cycles after reset release.
